matrix_scan_driver: RTL
=======================

Name: matrix_scan_driver

Overview:
- Drives the physical 5x7 LED matrix from the five 7-bit column words produced by the display-mode mux.
- Scans one column at a time, with a blanking cycle between columns.
- Snapshots the column words at each frame start so a frame never tears.
- Generates the periodic `selector` that alternates the mux between the state image and the water-level image.

Parameters:
- CLK_DIV, default 1000: clocks per column slot. Minimum 2.
- ALT_PERIOD, default 250: number of complete frames between `selector` toggles. Minimum 1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable.
- column_4  input  7  column word 4; bit 0 = top row, 1 = LED on.
- column_3  input  7  column word 3.
- column_2  input  7  column word 2.
- column_1  input  7  column word 1.
- column_0  input  7  column word 0.
- row_lines  output  7  row drive, active-low: 0 = LED on, 7'h7F = all off.
- column_select  output  5  one-hot, active-high column strobe; bit n selects column n.
- selector  output  1  mode select back to the display mux: 1 = state image, 0 = water image.
- frame_done  output  1  one-clock pulse on the last clock of each frame.

Behaviour:
- Reset (reset=1 at a clock edge) sets:
  - row_lines=7'h7F, column_select=5'b00000, selector=1, frame_done=0;
  - slot counter=0, column index=0, frame counter=0, snapshot=all zero.
- Reset mid-scan takes effect on that edge and overrides `enable`.
- Scan order per frame: column 0, 1, 2, 3, 4, then wrap to 0. Each column slot is CLK_DIV clocks.
- Slot counter runs 0..CLK_DIV-1.
  - At the end of the slot it wraps to 0 and the column index advances.
  - Column index wraps 4 -> 0.
- Blanking: slot count 0 is the blank cycle.
  - Registered outputs are row_lines=7'h7F, column_select=0.
  - Slot counts 1..CLK_DIV-1 drive:
    - column_select = one-hot(column index);
    - row_lines = ~snapshot[column index].
- Snapshot:
  - All five inputs are registered together on the blank cycle of the column 0 slot.
  - That snapshot is used for the entire frame. Input changes elsewhere in the frame are not visible until the next frame.
- Output latency: outputs are registered, so they reflect the counter state of the previous clock.
  - The first lit cycle of a column appears one clock after its blank cycle.
- frame_done:
  - Asserted for exactly one clock, registered, on the clock when slot count = CLK_DIV-1 and column index = 4.
  - It is the last lit cycle of column 4.
- Frame counter and selector:
  - The frame counter increments on each frame_done.
  - On the frame_done where frame counter = ALT_PERIOD-1, the counter clears to 0 and `selector` inverts.
  - With ALT_PERIOD=1, `selector` toggles every frame.
  - The new `selector` value is captured by the next frame's snapshot, because it is issued before the next column-0 blank cycle.
- Disabled behaviour: while enable=0,
  - row_lines=7'h7F, column_select=0, frame_done=0;
  - slot counter and column index are forced to 0;
  - frame counter and `selector` hold.
  - On the first enabled clock the scan restarts with the column 0 blank cycle and a fresh snapshot.
- Invariants:
  - column_select is never multi-hot.
  - column_select=0 whenever row_lines=7'h7F due to blanking or disable.
- Counter widths: sized with $clog2 of CLK_DIV and ALT_PERIOD. No overflow is possible by construction.

Test Plan:
- Reset behaviour (CLK_DIV=4, ALT_PERIOD=2): hold reset 3 clocks with enable=1.
  - Required: row_lines=7'h7F, column_select=0, selector=1, frame_done=0 throughout.
- Basic scan: column_0..column_4 = 7'h01, 02, 04, 08, 10, enable=1.
  - Required per 4-clock slot: one blank cycle (7F/00000), then 3 cycles of row_lines=~word with column_select = 00001, 00010, 00100, 01000, 10000 in turn.
  - Frame length is 20 clocks.
- Tear-free snapshot: change column_2 from 7'h04 to 7'h7F during the column 1 slot.
  - Required: the column 2 slot still drives row_lines=7'h7B.
  - The next frame drives 7'h00.
- Selector alternation:
  - Required: frame_done pulses exactly once per 20 clocks.
  - `selector` goes 1 -> 0 after the 2nd frame_done and 0 -> 1 after the 4th.
- Enable gating: deassert enable mid column 3 for 5 clocks, then reassert.
  - Required: outputs blank and no frame_done while disabled.
  - `selector` and frame count are unchanged.
  - The scan resumes at the column 0 blank cycle.
- Reset mid-frame: assert reset during the column 4 slot with selector=0.
  - Required: the next cycle shows all reset values, including selector=1, and there is no frame_done pulse.

Source files
------------

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: column-multiplexed driver for a 5x7 LED matrix.
// Each column slot is CLK_DIV clocks long. Slot count 0 is a blanking cycle,
// and the remaining counts light the column. All five column words are
// captured together on the column-0 blanking cycle, so a frame never shows a
// mix of old and new data. The block also toggles `selector` every ALT_PERIOD
// frames, which flips the display mux between its two images.
module matrix_scan_driver #(
    parameter int CLK_DIV    = 1000,
    parameter int ALT_PERIOD = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [6:0] row_lines,
    output logic [4:0] column_select,
    output logic       selector,
    output logic       frame_done
);

    localparam int SW = $clog2(CLK_DIV);
    localparam int FW = (ALT_PERIOD > 1) ? $clog2(ALT_PERIOD) : 1;

    localparam logic [SW-1:0] SLOT_ZERO  = SW'(0);
    localparam logic [SW-1:0] SLOT_ONE   = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FRAME_ZERO = FW'(0);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(ALT_PERIOD - 1);
    localparam logic [2:0]    COL_ZERO   = 3'd0;
    localparam logic [2:0]    COL_LAST   = 3'd4;
    localparam logic [6:0]    ROWS_OFF   = 7'h7F;

    // One-hot column strobe for a column index; out-of-range indices strobe nothing.
    function automatic logic [4:0] col_onehot(input logic [2:0] idx);
        logic [4:0] oh;
        case (idx)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    logic [SW-1:0] slot_q,  slot_d;
    logic [2:0]    col_q,   col_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          sel_q,   sel_d;
    logic [6:0]    snap_q [5];
    logic [6:0]    snap_d [5];
    logic [6:0]    row_q,   row_d;
    logic [4:0]    cs_q,    cs_d;
    logic          fd_q,    fd_d;
    logic [6:0]    cur_word_s;
    logic          last_slot_s;
    logic          last_col_s;

    // Pick the snapshot word for the column currently being scanned.
    always_comb begin
        cur_word_s = 7'h00;
        case (col_q)
            3'd0:    cur_word_s = snap_q[0];
            3'd1:    cur_word_s = snap_q[1];
            3'd2:    cur_word_s = snap_q[2];
            3'd3:    cur_word_s = snap_q[3];
            3'd4:    cur_word_s = snap_q[4];
            default: cur_word_s = 7'h00;
        endcase
    end

    // Next-state for the scan counters, snapshot, frame/selector logic and registered outputs.
    always_comb begin
        slot_d      = slot_q;
        col_d       = col_q;
        frame_d     = frame_q;
        sel_d       = sel_q;
        snap_d      = snap_q;
        row_d       = ROWS_OFF;
        cs_d        = 5'b00000;
        fd_d        = 1'b0;
        last_slot_s = (slot_q == SLOT_LAST);
        last_col_s  = (col_q == COL_LAST);

        if (!enable) begin
            // Parked: restart from the column-0 blank cycle when re-enabled.
            slot_d = SLOT_ZERO;
            col_d  = COL_ZERO;
        end else begin
            // The column-0 blank cycle captures the whole frame at once.
            if ((slot_q == SLOT_ZERO) && (col_q == COL_ZERO)) begin
                snap_d[0] = column_0;
                snap_d[1] = column_1;
                snap_d[2] = column_2;
                snap_d[3] = column_3;
                snap_d[4] = column_4;
            end else begin
                snap_d = snap_q;
            end

            if (slot_q != SLOT_ZERO) begin
                cs_d  = col_onehot(col_q);
                row_d = ~cur_word_s;
            end else begin
                cs_d  = 5'b00000;
                row_d = ROWS_OFF;
            end

            if (last_slot_s) begin
                slot_d = SLOT_ZERO;
                if (last_col_s) begin
                    col_d = COL_ZERO;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end else begin
                slot_d = slot_q + SLOT_ONE;
                col_d  = col_q;
            end

            fd_d = last_slot_s && last_col_s;

            // Selector flips on the frame end that completes ALT_PERIOD frames.
            if (fd_d) begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = FRAME_ZERO;
                    sel_d   = ~sel_q;
                end else begin
                    frame_d = frame_q + FRAME_ONE;
                    sel_d   = sel_q;
                end
            end else begin
                frame_d = frame_q;
                sel_d   = sel_q;
            end
        end
    end

    // State and output registers with synchronous reset that overrides enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q  <= SLOT_ZERO;
            col_q   <= COL_ZERO;
            frame_q <= FRAME_ZERO;
            sel_q   <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                snap_q[i] <= 7'h00;
            end
            row_q   <= ROWS_OFF;
            cs_q    <= 5'b00000;
            fd_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            col_q   <= col_d;
            frame_q <= frame_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            cs_q    <= cs_d;
            fd_q    <= fd_d;
        end
    end

    assign row_lines     = row_q;
    assign column_select = cs_q;
    assign selector      = sel_q;
    assign frame_done    = fd_q;

endmodule
